fraction_mac: RTL and testbench

Multi-channel, parametrised shift-add fractional multiply-accumulate for the additive oscillator datapath. Computes term = (multiple / 2^FRAC_BITS) * in by serial shift-add, one multiplier bit per clock. It adds the term into one of NUM_CHANNELS signed accumulators and supports early termination, a ready/start/done handshake, per-channel readback and optional saturation.

---
 rtl/fraction_mac_pkg.sv | 16 +
 rtl/fraction_mac_core.sv | 55 +++++
 rtl/fraction_mac.sv | 67 ++++++
 tb/tb_fraction_mac.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fraction_mac_pkg.sv
// fraction_mac_pkg: FSM state type, channel-width function and sign-extend/saturate helpers shared by fraction_mac and its core
package fraction_mac_pkg;
  localparam int WMAX = 64;
  typedef enum logic {IDLE, MULT} state_t;
  function automatic int ch_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic signed [WMAX-1:0] sext(input logic [WMAX-1:0] v, input int w);
    return $signed(v << (WMAX - w)) >>> (WMAX - w);
  endfunction
  function automatic logic signed [WMAX-1:0] sat(input logic signed [WMAX-1:0] v, input int w);
    logic signed [WMAX-1:0] hi;
    hi = (WMAX'(1) << (w - 1)) - WMAX'(1);
    return v > hi ? hi : v < -hi - WMAX'(1) ? -hi - WMAX'(1) : v;
  endfunction
endpackage

// File: rtl/fraction_mac_core.sv
// fraction_mac_core: serial shift-add multiplier, one multiplier bit per clock; in: clock, reset_n, start, multiple, in; out: ready, commit strobe, term = (in*multiple) >>> FRAC_BITS
module fraction_mac_core
  import fraction_mac_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS = 7
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  start,
  input  logic [FRAC_BITS-1:0]                  multiple,
  input  logic signed [DATA_WIDTH-1:0]          in,
  output logic                                  ready,
  output logic                                  commit,
  output logic signed [DATA_WIDTH+FRAC_BITS-1:0] term
);
  localparam int PW = DATA_WIDTH + FRAC_BITS;
  localparam int BW = $clog2(FRAC_BITS + 1);
  state_t state, state_nx;
  logic accept;
  logic [FRAC_BITS-1:0] mult_reg;
  logic [BW-1:0] bit_idx;
  logic signed [DATA_WIDTH-1:0] in_reg;
  logic signed [PW-1:0] product, in_ext, reg_ext;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    accept = state == IDLE && start;
    state_nx = accept ? MULT : (state == MULT && mult_reg == '0) ? IDLE : state;
  end
  always_comb begin
    ready = state == IDLE;
    commit = state == MULT && mult_reg == '0;
  end
  assign in_ext = PW'(sext(WMAX'(in), DATA_WIDTH));
  assign reg_ext = PW'(sext(WMAX'(in_reg), DATA_WIDTH));
  assign term = product >>> FRAC_BITS;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      product <= '0;
      mult_reg <= '0;
      bit_idx <= '0;
      in_reg <= '0;
    end else if (accept) begin
      product <= multiple[0] ? in_ext : '0;
      in_reg <= in;
      mult_reg <= multiple >> 1;
      bit_idx <= BW'(1);
    end else if (state == MULT && mult_reg != '0) begin
      product <= mult_reg[0] ? product + (reg_ext << bit_idx) : product;
      mult_reg <= mult_reg >> 1;
      bit_idx <= bit_idx + BW'(1);
    end
endmodule

// File: rtl/fraction_mac.sv
// fraction_mac: multi-channel fractional MAC (acc[channel] += in*multiple>>>FRAC_BITS) with start/ready/done handshake, clear_all, rd_channel readback on acc_out; define FRACTION_MAC_SAT_EN to saturate instead of wrap
module fraction_mac
  import fraction_mac_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS = 7,
  parameter int ACC_WIDTH = 32,
  parameter int NUM_CHANNELS = 4,
  localparam int CH_BITS = ch_bits(NUM_CHANNELS)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  output logic                         ready,
  input  logic [FRAC_BITS-1:0]         multiple,
  input  logic signed [DATA_WIDTH-1:0] in,
  input  logic [CH_BITS-1:0]           channel,
  input  logic                         clear_all,
  input  logic [CH_BITS-1:0]           rd_channel,
  output logic [ACC_WIDTH-1:0]         acc_out,
  output logic                         done,
  output logic [CH_BITS-1:0]           done_channel
);
  localparam int PW = DATA_WIDTH + FRAC_BITS;
  logic commit;
  logic signed [PW-1:0] term;
  logic [CH_BITS-1:0] ch_reg;
  logic signed [ACC_WIDTH-1:0] acc [NUM_CHANNELS];
  logic signed [ACC_WIDTH-1:0] acc_sel, acc_new;
  fraction_mac_core #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_core (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .multiple(multiple),
    .in(in),
    .ready(ready),
    .commit(commit),
    .term(term)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) ch_reg <= '0;
    else if (ready && start) ch_reg <= channel;
  always_comb begin
    acc_out = '0;
    acc_sel = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      acc_out = CH_BITS'(i) == rd_channel ? acc[i] : acc_out;
      acc_sel = (CH_BITS'(i) == ch_reg && !clear_all) ? acc[i] : acc_sel;
    end
`ifdef FRACTION_MAC_SAT_EN
    acc_new = ACC_WIDTH'(sat(sext(WMAX'(acc_sel), ACC_WIDTH) + sext(WMAX'(term), PW), ACC_WIDTH));
`else
    acc_new = ACC_WIDTH'(sext(WMAX'(acc_sel), ACC_WIDTH) + sext(WMAX'(term), PW));
`endif
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      done <= 1'b0;
      done_channel <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) acc[i] <= '0;
    end else begin
      done <= commit;
      done_channel <= commit ? ch_reg : done_channel;
      for (int i = 0; i < NUM_CHANNELS; i++)
        acc[i] <= (commit && CH_BITS'(i) == ch_reg) ? acc_new : clear_all ? '0 : acc[i];
    end
endmodule

// File: tb/tb_fraction_mac.sv
// tb_fraction_mac: scoreboard bench for fraction_mac with a floor-division reference model and a 16-bit-accumulator instance for wrap/saturation
module tb_fraction_mac;
  typedef struct {int ch; longint acc; longint cyc;} exp_t;
  logic clock = 0, reset_n = 0, start = 0, clear_all = 0;
  logic [6:0] multiple = 0;
  logic signed [15:0] in_s = 0;
  logic [1:0] channel = 0, rd_channel = 0;
  logic [31:0] acc_out;
  logic ready, done;
  logic [1:0] done_channel;
  logic w_start = 0, w_ready, w_done;
  logic [1:0] w_dc;
  logic [15:0] w_acc;
  longint cyc = 0;
  int checks = 0, passes = 0;
  exp_t sb[$];
  longint model[4];

  fraction_mac u_dut (
    .clock(clock), .reset_n(reset_n), .start(start), .ready(ready),
    .multiple(multiple), .in(in_s), .channel(channel), .clear_all(clear_all),
    .rd_channel(rd_channel), .acc_out(acc_out), .done(done), .done_channel(done_channel)
  );
  fraction_mac #(.ACC_WIDTH(16)) u_w (
    .clock(clock), .reset_n(reset_n), .start(w_start), .ready(w_ready),
    .multiple(7'd127), .in(16'sd32767), .channel(2'd0), .clear_all(1'b0),
    .rd_channel(2'd0), .acc_out(w_acc), .done(w_done), .done_channel(w_dc)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string nm, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, req);
  endfunction

  function automatic longint term_of(input longint x, input longint mul);
    longint p = x * mul;
    return p >= 0 ? p / 128 : -((-p + 127) / 128);
  endfunction

  function automatic longint wrap(input longint v, input int w);
    longint m = longint'(1) << w;
    longint r = ((v % m) + m) % m;
    return r >= m / 2 ? r - m : r;
  endfunction

  always @(negedge clock) if (done) begin
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("FAIL spurious_done: done on ch %0d with no operation outstanding", done_channel);
    end else begin
      e = sb.pop_front();
      chk("done_channel", done_channel, e.ch);
      chk("latency_cycle", cyc, e.cyc);
      rd_channel = done_channel;
      #1;
      chk("acc_on_commit", $signed(acc_out), e.acc);
    end
  end

  task automatic issue(input int ch, input int mul, input int x, input bit hold, input bit clr);
    exp_t e;
    int m = 0;
    @(negedge clock);
    for (int i = 0; i < 50 && !ready; i++) @(negedge clock);
    if (!ready) begin
      checks++;
      $display("FAIL ready_timeout: ready=%0b after 50 cycles, required 1", ready);
    end
    for (int b = 0; b < 7; b++) if (((mul >> b) & 1) == 1) m = b;
    start = 1; multiple = 7'(mul); in_s = 16'(x); channel = 2'(ch);
    @(posedge clock); #1;
    chk("ready_busy", ready, 0);
    if (clr) foreach (model[i]) model[i] = 0;
    model[ch] = wrap(model[ch] + term_of(x, mul), 32);
    e.ch = ch; e.acc = model[ch]; e.cyc = cyc + 1 + m;
    sb.push_back(e);
    if (hold) begin @(posedge clock); #1; end
    start = 0;
    if (clr) begin
      repeat (m) @(posedge clock);
      @(negedge clock); clear_all = 1;
      @(posedge clock); #1; clear_all = 0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d operations never completed, required 0", sb.size());
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic rd_chk(input int ch, input longint req, input string nm);
    rd_channel = 2'(ch); #1;
    chk(nm, $signed(acc_out), req);
  endtask

  task automatic clr();
    @(negedge clock); clear_all = 1;
    @(posedge clock); #1; clear_all = 0;
    foreach (model[i]) model[i] = 0;
  endtask

  initial begin
    longint w_exp[2], s, t0;
    foreach (model[i]) model[i] = 0;
    repeat (3) @(negedge clock);
    reset_n = 1;
    @(negedge clock);
    chk("reset_ready", ready, 1);
    chk("reset_done", done, 0);
    chk("reset_done_channel", done_channel, 0);
    for (int i = 0; i < 4; i++) rd_chk(i, 0, "reset_acc");

    issue(0, 64, 1000, 0, 0);
    issue(1, 3, -1000, 0, 0);
    issue(3, 64, 154, 0, 0);
    issue(3, 0, 32767, 1, 0);
    drain();
    rd_chk(0, 500, "half_1000");
    rd_chk(1, -24, "floor_negative");
    rd_chk(3, 77, "mult_zero_keeps");

    clr();
    issue(2, 64, 200, 0, 0);
    issue(0, 64, 10, 0, 0);
    drain();
    rd_chk(2, 100, "preload_ch2");
    issue(2, 2, 256, 0, 1);
    drain();
    rd_chk(0, 0, "clear_commit_ch0");
    rd_chk(1, 0, "clear_commit_ch1");
    rd_chk(2, 4, "clear_commit_ch2");
    rd_chk(3, 0, "clear_commit_ch3");

    w_exp[0] = term_of(32767, 127);
    s = 2 * w_exp[0];
`ifdef FRACTION_MAC_SAT_EN
    w_exp[1] = s > 32767 ? 32767 : s;
`else
    w_exp[1] = wrap(s, 16);
`endif
    @(negedge clock); w_start = 1;
    for (int k = 0; k < 2; k++) begin
      int n = 0;
      @(negedge clock);
      while (!w_done && n < 40) begin @(negedge clock); n++; end
      chk("wide_done", w_done, 1);
      chk(k == 0 ? "wide_acc_first" : "wide_acc_second", $signed(w_acc), w_exp[k]);
      chk("wide_ready_after", w_ready, 1);
      if (k == 0) t0 = cyc;
      else chk("back_to_back_gap", cyc - t0, 8);
    end
    w_start = 0;

    issue(1, 127, 12345, 0, 0);
    repeat (3) @(posedge clock);
    #1 reset_n = 0;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    for (int i = 0; i < 4; i++) rd_chk(i, 0, "abort_acc");
    void'(sb.pop_back());
    foreach (model[i]) model[i] = 0;
    @(negedge clock); reset_n = 1;
    repeat (10) @(negedge clock);
    chk("abort_no_done", done, 0);

    issue(2, 64, 1000, 0, 0);
    drain();
    rd_chk(2, 500, "fresh_after_abort");

    for (int k = 0; k < 40; k++) begin
      issue($urandom_range(0, 3), $urandom_range(0, 127), $urandom_range(0, 65535) - 32768, 0, 0);
      repeat ($urandom_range(0, 2)) @(posedge clock);
    end
    drain();
    for (int i = 0; i < 4; i++) rd_chk(i, model[i], "final_acc");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
